dma_aipe_sram_resp: RTL and testbench
=====================================

# dma_aipe_sram_resp

Responder for the 128-bit AiPE-side SRAM port driven by the data DMA engine. It stores AiPE operand/result words and serves two requesters: the dDMA initiator (strict priority, no back-pressure) and the AiPE compute core (stallable). Reads are pipelined with a fixed two-cycle latency, and read data is held stable until the next read completes. The block sits between the dDMA engine and the AiPE datapath in the peripherals part of the SoC.

## Interface
- ADDR_W, 8, word-address width; depth = 2^ADDR_W words of 128 bits
- i_clk  in  1  single clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_dDMA_AIPE_rden  in  1  dDMA read request, one word per cycle
- i_dDMA_AIPE_wren  in  1  dDMA write request
- i_dDMA_AIPE_addr  in  32  dDMA word address
- i_dDMA_AIPE_wdata  in  128  dDMA write data
- o_dDMA_AIPE_rdata  out  128  dDMA read data, held until the next dDMA read returns
- o_dDMA_AIPE_rvalid  out  1  one-cycle pulse marking new o_dDMA_AIPE_rdata
- i_aipe_rden / i_aipe_wren  in  1  core read / write request
- i_aipe_addr  in  ADDR_W  core word address
- i_aipe_wdata  in  128  core write data
- o_aipe_rdata  out  128  core read data, held
- o_aipe_rvalid  out  1  core read-valid pulse
- o_aipe_stall  out  1  combinational; core request not accepted this cycle, core holds it
- i_clr_err  in  1  clears o_oor_err and d_cnt_conflict_8b
- o_oor_err  out  1  sticky: dDMA address out of range
- d_cnt_conflict_8b  out  8  saturating count of stalled core cycles

## Operation
- A port request is any cycle with rden or wren high. A dDMA request is always accepted.
- o_aipe_stall = (core request) AND (dDMA request). A stalled core request has no effect. The core must repeat it.
- If wren and rden are both high on one port, the write is performed and the read is dropped: no rvalid is produced.
- Write: memory is updated at the clock edge that ends the accepted cycle. A read issued in the next cycle to the same address returns the new data.
- A read and a write to the same address in the same cycle can only come from different ports, and dDMA wins. This case therefore cannot occur.
- dDMA out of range means i_dDMA_AIPE_addr[31:ADDR_W] != 0:
  - A write is discarded.
  - A read returns 128'b0 with a normal rvalid pulse.
  - o_oor_err is set in both cases.
- The core address is always in range.
- Read pipeline per port:
  - Stage 1 registers the port tag and memory output.
  - Stage 2 drives rdata/rvalid.
  - Each port has an independent valid bit and tag. Back-to-back reads every cycle are supported.
- d_cnt_conflict_8b increments on each cycle with o_aipe_stall=1 and saturates at 255.
- i_clr_err zeroes both the counter and o_oor_err. If a conflict occurs in the same cycle as the clear, the clear wins.

## Timing
- Read latency: a request accepted in cycle C produces rvalid=1 and the new rdata in cycle C+2. rdata stays constant from C+2 until the next read's C'+2.
- The dDMA engine asserts rden at edge E0 and samples rdata at E3 without checking rvalid. The holding behaviour is therefore mandatory.
- Write latency: the update is visible to reads accepted in C+1 and later.
- Reset values:
  - All rdata outputs 128'b0.
  - rvalid outputs 0.
  - o_oor_err 0.
  - Counter 0.
  - Pipeline valid bits 0.
- Memory contents are not reset.
- If reset is asserted mid-read, in-flight reads are dropped and no rvalid follows reset release.
- o_aipe_stall is purely combinational from the current-cycle requests and has no registered dependency.

## Test plan
- dDMA writes 0x0123...CDEF to addr 5, then reads addr 5 in the next cycle -> rvalid in cycle +2 with identical data; rdata is still equal one cycle later with rvalid=0.
- dDMA reads addrs 0..3 on consecutive cycles after preloading with values 0xA0..0xA3 -> four consecutive rvalid pulses with data in order and latency 2.
- Core writes addr 7 while dDMA reads addr 7 in the same cycle -> o_aipe_stall=1, memory unchanged, counter=1; the core retries next cycle and the write lands.
- dDMA reads addr 0x0000_0100 with ADDR_W=8 -> rdata=0 with rvalid pulse and o_oor_err=1; an out-of-range write leaves memory unchanged; i_clr_err clears the flag.
- The same port raises rden and wren together at addr 3 -> the write is performed and no rvalid is produced.
- Hold the conflict for 300 cycles -> counter saturates at 255. Assert reset with two reads in flight -> all outputs 0 and no rvalid after release.

Source files
------------

// File: rtl/dma_aipe_sram_resp.sv
// ---------------------------------------------------------------------------
// dma_aipe_sram_resp
//
// 128-bit AiPE-side SRAM responder shared by the dDMA initiator and the AiPE
// compute core.
//
// Access rules:
//   - The dDMA port has strict priority and is never back-pressured.
//   - A core request in the same cycle as any dDMA request is stalled and
//     has no effect.
//   - Reads return after a fixed two-cycle latency.
//   - Each port's read data stays on its output until that port's next read
//     returns.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_dDMA_AIPE_rden/wren    dDMA read / write request
//   i_dDMA_AIPE_addr         dDMA word address (32 bits, range-checked)
//   i_dDMA_AIPE_wdata        dDMA write data
//   o_dDMA_AIPE_rdata/rvalid dDMA read data (held) and new-data pulse
//   i_aipe_rden/wren         core read / write request
//   i_aipe_addr              core word address (always in range)
//   i_aipe_wdata             core write data
//   o_aipe_rdata/rvalid      core read data (held) and new-data pulse
//   o_aipe_stall             core request not accepted this cycle
//   i_clr_err                clears o_oor_err and the conflict counter
//   o_oor_err                sticky dDMA out-of-range flag
//   d_cnt_conflict_8b        saturating count of stalled core cycles
// ---------------------------------------------------------------------------
module dma_aipe_sram_resp #(
  parameter int ADDR_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_dDMA_AIPE_rden,
  input  logic          i_dDMA_AIPE_wren,
  input  logic [31:0]   i_dDMA_AIPE_addr,
  input  logic [127:0]  i_dDMA_AIPE_wdata,
  output logic [127:0]  o_dDMA_AIPE_rdata,
  output logic          o_dDMA_AIPE_rvalid,
  input  logic          i_aipe_rden,
  input  logic          i_aipe_wren,
  input  logic [ADDR_W-1:0] i_aipe_addr,
  input  logic [127:0]  i_aipe_wdata,
  output logic [127:0]  o_aipe_rdata,
  output logic          o_aipe_rvalid,
  output logic          o_aipe_stall,
  input  logic          i_clr_err,
  output logic          o_oor_err,
  output logic [7:0]    d_cnt_conflict_8b
);

  localparam int DATA_W = 128;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ddma_req;
  logic              aipe_req;
  logic              ddma_oor;
  logic              ddma_rd;
  logic              ddma_wr;
  logic              aipe_rd;
  logic              aipe_wr;
  logic [ADDR_W-1:0] ddma_idx;
  logic [ADDR_W-1:0] rd_addr;

  // Request decode. A write on a port suppresses that port's read.
  assign ddma_req     = i_dDMA_AIPE_rden | i_dDMA_AIPE_wren;
  assign aipe_req     = i_aipe_rden | i_aipe_wren;
  assign o_aipe_stall = aipe_req & ddma_req;
  assign ddma_oor     = |i_dDMA_AIPE_addr[31:ADDR_W];
  assign ddma_idx     = i_dDMA_AIPE_addr[ADDR_W-1:0];
  assign ddma_rd      = i_dDMA_AIPE_rden & ~i_dDMA_AIPE_wren;
  assign ddma_wr      = i_dDMA_AIPE_wren & ~ddma_oor;
  assign aipe_rd      = i_aipe_rden & ~i_aipe_wren & ~ddma_req;
  assign aipe_wr      = i_aipe_wren & ~ddma_req;

  // At most one port is accepted per cycle, so one read address suffices.
  assign rd_addr = ddma_req ? ddma_idx : i_aipe_addr;

  // Memory array: no reset.
  // A same-address read/write pair can only come from different ports,
  // and the loser is stalled, so the read never races the write.
  always_ff @(posedge i_clk) begin
    if (ddma_wr) begin
      mem_q[ddma_idx] <= i_dDMA_AIPE_wdata;
    end else if (aipe_wr) begin
      mem_q[i_aipe_addr] <= i_aipe_wdata;
    end
  end

  // ---- Stage 1: shared read-data register plus per-port valid/tag ----
  logic [DATA_W-1:0] rd_data_p1;
  logic              ddma_vld_p1;
  logic              aipe_vld_p1;

  always_ff @(posedge i_clk) begin
    if (ddma_rd || aipe_rd) begin
      // Out-of-range dDMA reads return zero rather than an aliased word.
      rd_data_p1 <= (ddma_rd && ddma_oor) ? '0 : mem_q[rd_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ddma_vld_p1 <= 1'b0;
      aipe_vld_p1 <= 1'b0;
    end else begin
      ddma_vld_p1 <= ddma_rd;
      aipe_vld_p1 <= aipe_rd;
    end
  end

  // ---- Stage 2: per-port held read data and valid pulse ----
  logic [DATA_W-1:0] ddma_rdata_q;
  logic              ddma_rvalid_q;
  logic [DATA_W-1:0] aipe_rdata_q;
  logic              aipe_rvalid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ddma_rdata_q  <= '0;
      ddma_rvalid_q <= 1'b0;
      aipe_rdata_q  <= '0;
      aipe_rvalid_q <= 1'b0;
    end else begin
      ddma_rvalid_q <= ddma_vld_p1;
      aipe_rvalid_q <= aipe_vld_p1;
      // Data only moves when the port's own read completes; the dDMA engine
      // samples rdata blind one cycle late, so holding is essential.
      if (ddma_vld_p1) ddma_rdata_q <= rd_data_p1;
      if (aipe_vld_p1) aipe_rdata_q <= rd_data_p1;
    end
  end

  assign o_dDMA_AIPE_rdata  = ddma_rdata_q;
  assign o_dDMA_AIPE_rvalid = ddma_rvalid_q;
  assign o_aipe_rdata       = aipe_rdata_q;
  assign o_aipe_rvalid      = aipe_rvalid_q;

  // Error flag and conflict counter; a clear beats a same-cycle event.
  logic       oor_err_q;
  logic       oor_err_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    oor_err_d = oor_err_q;
    cnt_d     = cnt_q;
    if (i_clr_err) begin
      oor_err_d = 1'b0;
      cnt_d     = 8'd0;
    end else begin
      if (ddma_req && ddma_oor) oor_err_d = 1'b1;
      if (o_aipe_stall && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oor_err_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      oor_err_q <= oor_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_oor_err         = oor_err_q;
  assign d_cnt_conflict_8b = cnt_q;

endmodule

// File: tb/tb_dma_aipe_sram_resp.sv
// Testbench for dma_aipe_sram_resp: directed stimulus, a transaction-level
// reference model (word array + queues of due read returns) compared every
// cycle, plus literal expectations at key points.
module tb_dma_aipe_sram_resp;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         d_rd = 1'b0;
  logic         d_wr = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [127:0] d_wdata = '0;
  logic [127:0] d_rdata;
  logic         d_rvalid;
  logic         a_rd = 1'b0;
  logic         a_wr = 1'b0;
  logic [7:0]   a_addr = '0;
  logic [127:0] a_wdata = '0;
  logic [127:0] a_rdata;
  logic         a_rvalid;
  logic         a_stall;
  logic         clr = 1'b0;
  logic         oor_err;
  logic [7:0]   cnt;

  dma_aipe_sram_resp #(.ADDR_W(8)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_dDMA_AIPE_rden   (d_rd),
    .i_dDMA_AIPE_wren   (d_wr),
    .i_dDMA_AIPE_addr   (d_addr),
    .i_dDMA_AIPE_wdata  (d_wdata),
    .o_dDMA_AIPE_rdata  (d_rdata),
    .o_dDMA_AIPE_rvalid (d_rvalid),
    .i_aipe_rden        (a_rd),
    .i_aipe_wren        (a_wr),
    .i_aipe_addr        (a_addr),
    .i_aipe_wdata       (a_wdata),
    .o_aipe_rdata       (a_rdata),
    .o_aipe_rvalid      (a_rvalid),
    .o_aipe_stall       (a_stall),
    .i_clr_err          (clr),
    .o_oor_err          (oor_err),
    .d_cnt_conflict_8b  (cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; logic [127:0] d; } rd_t;
  rd_t          qd[$];
  rd_t          qa[$];
  logic [127:0] mm [256];
  logic [127:0] held_d = '0;
  logic [127:0] held_a = '0;
  int           m_cnt = 0;
  logic         m_err = 1'b0;
  int           cyc = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        qd.delete();
        qa.delete();
        held_d = '0;
        held_a = '0;
        m_cnt  = 0;
        m_err  = 1'b0;
      end else begin
        logic dreq, areq, stl, oor;
        rd_t  e;
        dreq = d_rd | d_wr;
        areq = a_rd | a_wr;
        stl  = dreq & areq;
        oor  = (d_addr[31:8] != 24'd0);
        if (d_rd && !d_wr) begin
          e.due = cyc + 2;
          e.d   = oor ? 128'd0 : mm[d_addr[7:0]];
          qd.push_back(e);
        end
        if (!stl && a_rd && !a_wr) begin
          e.due = cyc + 2;
          e.d   = mm[a_addr];
          qa.push_back(e);
        end
        if (d_wr && !oor) mm[d_addr[7:0]] = d_wdata;
        else if (a_wr && !stl) mm[a_addr] = a_wdata;
        if (clr) begin
          m_cnt = 0;
          m_err = 1'b0;
        end else begin
          if (stl && m_cnt < 255) m_cnt++;
          if (dreq && oor) m_err = 1'b1;
        end
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      logic exp_dv, exp_av;
      @(negedge clk);
      exp_dv = 1'b0;
      exp_av = 1'b0;
      if (qd.size() > 0 && qd[0].due == cyc) begin
        exp_dv = 1'b1;
        held_d = qd[0].d;
        void'(qd.pop_front());
      end
      if (qa.size() > 0 && qa[0].due == cyc) begin
        exp_av = 1'b1;
        held_a = qa[0].d;
        void'(qa.pop_front());
      end
      chk("m_ddma_rvalid", {127'd0, d_rvalid}, {127'd0, exp_dv});
      chk("m_ddma_rdata", d_rdata, held_d);
      chk("m_aipe_rvalid", {127'd0, a_rvalid}, {127'd0, exp_av});
      chk("m_aipe_rdata", a_rdata, held_a);
      chk("m_stall", {127'd0, a_stall}, {127'd0, ((d_rd | d_wr) & (a_rd | a_wr))});
      chk("m_oor_err", {127'd0, oor_err}, {127'd0, m_err});
      chk("m_cnt", {120'd0, cnt}, m_cnt[127:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic drd, input logic dwr, input logic [31:0] dad,
                       input logic [127:0] dwd, input logic ard, input logic awr,
                       input logic [7:0] aad, input logic [127:0] awd, input logic c);
    d_rd = drd; d_wr = dwr; d_addr = dad; d_wdata = dwd;
    a_rd = ard; a_wr = awr; a_addr = aad; a_wdata = awd; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  localparam logic [127:0] DATA1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] OLD7  = 128'h7777_0000_0000_0000_0000_0000_0000_0007;
  localparam logic [127:0] NEW7  = 128'hC0DE_0000_0000_0000_0000_0000_0000_C0DE;
  localparam logic [127:0] JUNK  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] BVAL  = 128'hB3B3_B3B3_0000_0000_0000_0000_B3B3_B3B3;

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rdata", d_rdata, 128'd0);
    chk("rst_cnt", {120'd0, cnt}, 128'd0);
    rst_n = 1'b1;
    idle(1);

    // write addr 5, read it back next cycle
    drive(0, 1, 32'd5, DATA1, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 32'd5, 0, 0, 0, 0, 0, 0); tick();
    idle(1);
    chk("t1_rvalid", {127'd0, d_rvalid}, 128'd1);
    chk("t1_rdata", d_rdata, DATA1);
    idle(1);
    chk("t1_rvalid_low", {127'd0, d_rvalid}, 128'd0);
    chk("t1_rdata_held", d_rdata, DATA1);

    // preload 0..3, back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, i, 128'hA0 + i, 0, 0, 0, 0, 0); tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i, 0, 0, 0, 0, 0, 0); tick();
    end
    idle(1);
    chk("t2_last", d_rdata, 128'hA3);
    idle(1);

    // conflict: core write vs dDMA read on addr 7
    drive(0, 1, 32'd7, OLD7, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 0, 32'd7, 0, 0, 1, 8'd7, NEW7, 0);
    #1 chk("t3_stall", {127'd0, a_stall}, 128'd1);
    tick();
    chk("t3_cnt", {120'd0, cnt}, 128'd1);
    drive(0, 0, 0, 0, 0, 1, 8'd7, NEW7, 0); tick();
    chk("t3_old", d_rdata, OLD7);
    drive(1, 0, 32'd7, 0, 0, 0, 0, 0, 0); tick();
    idle(1);
    chk("t3_new", d_rdata, NEW7);
    drive(0, 0, 0, 0, 1, 0, 8'd7, 0, 0); tick();
    idle(1);
    chk("t3_core_rd", a_rdata, NEW7);
    chk("t3_core_rv", {127'd0, a_rvalid}, 128'd1);

    // out of range
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0); tick();
    idle(1);
    chk("t4_rdata", d_rdata, 128'd0);
    chk("t4_rvalid", {127'd0, d_rvalid}, 128'd1);
    chk("t4_err", {127'd0, oor_err}, 128'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("t4_clr", {127'd0, oor_err}, 128'd0);
    drive(0, 1, 32'h105, JUNK, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 32'd5, 0, 0, 0, 0, 0, 0); tick();
    idle(1);
    chk("t4_mem", d_rdata, DATA1);
    chk("t4_err2", {127'd0, oor_err}, 128'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();

    // rden+wren together on one port
    drive(1, 1, 32'd3, BVAL, 0, 0, 0, 0, 0); tick();
    idle(2);
    chk("t5_norv", {127'd0, d_rvalid}, 128'd0);
    drive(1, 0, 32'd3, 0, 0, 0, 0, 0, 0); tick();
    idle(1);
    chk("t5_rd", d_rdata, BVAL);
    drive(0, 0, 0, 0, 1, 1, 8'd4, JUNK, 0); tick();
    idle(3);

    // saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 32'd0, 0, 1, 0, 8'd0, 0, 0); tick();
    end
    chk("t6_sat", {120'd0, cnt}, 128'd255);
    drive(1, 0, 32'd0, 0, 1, 0, 8'd0, 0, 1); tick();
    chk("t6_clr_wins", {120'd0, cnt}, 128'd0);
    idle(3);

    // reset with reads in flight
    drive(1, 0, 32'd1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 32'd2, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rdata", d_rdata, 128'd0);
    chk("t7_rvalid", {127'd0, d_rvalid}, 128'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    idle(4);
    chk("t7_post_rdata", d_rdata, 128'd0);
    chk("t7_post_rvalid", {127'd0, d_rvalid}, 128'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
